// File: rtl/gyro_pkg.sv
// gyro_pkg: shared definitions for the multi-channel gyro integrator.
//   - gyro_state_t : calibration / run sequencing states
//   - DEF_*        : default parameter values for gyro_integrator
//   - sat_add      : signed add clamped to a w-bit two's-complement range,
//                    used when GYRO_ACC_SAT_EN is defined
package gyro_pkg;

    typedef enum logic [1:0] {
        CAL_ACC = 2'd0,
        CAL_DIV = 2'd1,
        RUN     = 2'd2
    } gyro_state_t;

    localparam int DEF_NUM_CH    = 3;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ACC_W     = 48;
    localparam int DEF_CAL_LOG2  = 8;
    localparam int DEF_DEADBAND  = 200;
    localparam int DEF_OUT_SHIFT = 28;

    // Operands must already be sign-extended w-bit values (w <= 64), so the
    // 65-bit sum is exact and a simple compare against the limits suffices.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [64:0] s;
        logic signed [64:0] mx;
        logic signed [64:0] mn;
        s  = 65'(a) + 65'(b);
        mx = (65'sd1 <<< (w - 1)) - 65'sd1;
        mn = -mx - 65'sd1;
        if (s > mx)      return mx[63:0];
        else if (s < mn) return mn[63:0];
        else             return s[63:0];
    endfunction

endpackage

// File: rtl/gyro_chan.sv
// gyro_chan: one rate channel of the gyro integrator.
//   Holds the calibration sum, the bias, the deadband compare and the
//   angle accumulator. Sequencing comes from the top-level FSM as strobes.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        discard sum, bias, accumulator and angle (recalibration)
//   cal_acc      add rate into the calibration sum
//   cal_div      latch bias = sum / 2^CAL_LOG2
//   run          integrate the bias-corrected rate and update angle
//   rate         signed input rate
//   angle        registered signed angle (acc >>> OUT_SHIFT, truncated)
// Build option: GYRO_ACC_SAT_EN makes the accumulator saturate instead of wrap.
module gyro_chan
    import gyro_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CAL_LOG2  = DEF_CAL_LOG2,
    parameter int DEADBAND  = DEF_DEADBAND,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              cal_acc,
    input  logic              cal_div,
    input  logic              run,
    input  logic [DATA_W-1:0] rate,
    output logic [DATA_W-1:0] angle
);

    localparam int SUM_W = DATA_W + CAL_LOG2;
    localparam logic signed [DATA_W+1:0] DB = (DATA_W + 2)'(DEADBAND);

    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [DATA_W-1:0] bias_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  contrib;
    logic [DATA_W-1:0]        angle_reg;
    logic [DATA_W-1:0]        angle_next;
    logic signed [DATA_W-1:0] rate_s;
    logic signed [DATA_W:0]   corr;
    logic signed [DATA_W+1:0] corr_x;
    logic                     in_band;

    assign rate_s = $signed(rate);

    // One extra bit keeps rate - bias exact for any pair of DATA_W values.
    assign corr    = {rate_s[DATA_W-1], rate_s} - {bias_reg[DATA_W-1], bias_reg};
    assign corr_x  = {corr[DATA_W], corr};
    assign in_band = (corr_x <= DB) && (corr_x >= -DB);
    assign contrib = in_band ? '0 : {{(ACC_W - DATA_W - 1){corr[DATA_W]}}, corr};

`ifdef GYRO_ACC_SAT_EN
    assign acc_next = ACC_W'(sat_add(64'(acc_reg), 64'(contrib), ACC_W));
`else
    assign acc_next = acc_reg + contrib;
`endif

    // Angle is taken from the post-update accumulator so that it is valid in
    // the same cycle out_valid is raised.
    generate
        if (OUT_SHIFT + DATA_W <= ACC_W) begin : g_slice
            assign angle_next = acc_next[OUT_SHIFT +: DATA_W];
        end else begin : g_ext
            logic [ACC_W+DATA_W-1:0] acc_ext;
            assign acc_ext    = {{DATA_W{acc_next[ACC_W-1]}}, acc_next};
            assign angle_next = acc_ext[OUT_SHIFT +: DATA_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum_reg   <= '0;
            bias_reg  <= '0;
            acc_reg   <= '0;
            angle_reg <= '0;
        end else begin
            if (cal_acc) sum_reg <= sum_reg + SUM_W'(rate_s);
            // Exactly 2^CAL_LOG2 samples, so the upper DATA_W bits are the
            // arithmetic-shifted mean.
            if (cal_div) bias_reg <= sum_reg[CAL_LOG2 +: DATA_W];
            if (run) begin
                acc_reg   <= acc_next;
                angle_reg <= angle_next;
            end
        end
    end

    assign angle = angle_reg;

endmodule

// File: rtl/gyro_integrator.sv
// gyro_integrator: NUM_CH-channel gyro rate integrator with bias calibration.
//   Calibrates a per-channel bias over 2^CAL_LOG2 valid samples, then
//   integrates deadbanded, bias-corrected rates into wide accumulators.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   in_valid     in_rate carries a new sample set
//   in_rate      packed signed rates, channel i at [i*DATA_W +: DATA_W]
//   recal        pulse: drop bias/angles and restart calibration
//   angle_out    packed signed angles, same packing as in_rate
//   out_valid    angle_out updated this cycle
//   calibrating  high while in CAL_ACC or CAL_DIV
// Build option: GYRO_ACC_SAT_EN selects saturating accumulators.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CAL_LOG2  = DEF_CAL_LOG2,
    parameter int DEADBAND  = DEF_DEADBAND,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_rate,
    input  logic                     recal,
    output logic [NUM_CH*DATA_W-1:0] angle_out,
    output logic                     out_valid,
    output logic                     calibrating
);

    gyro_state_t         state_reg, state_next;
    logic [CAL_LOG2-1:0] cnt_reg, cnt_next;
    logic                out_valid_reg;
    logic                cal_acc, cal_div, run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= CAL_ACC;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= run;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cal_acc    = 1'b0;
        cal_div    = 1'b0;
        run        = 1'b0;
        if (recal) begin
            // Any sample in this cycle is dropped.
            state_next = CAL_ACC;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                CAL_ACC: begin
                    if (in_valid) begin
                        cal_acc  = 1'b1;
                        cnt_next = cnt_reg + CAL_LOG2'(1);
                        if (&cnt_reg) state_next = CAL_DIV;
                    end
                end
                CAL_DIV: begin
                    cal_div    = 1'b1;
                    state_next = RUN;
                end
                RUN:     run = in_valid;
                default: state_next = CAL_ACC;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            gyro_chan #(
                .DATA_W   (DATA_W),
                .ACC_W    (ACC_W),
                .CAL_LOG2 (CAL_LOG2),
                .DEADBAND (DEADBAND),
                .OUT_SHIFT(OUT_SHIFT)
            ) u_chan (
                .clk    (clk),
                .reset  (reset),
                .clear  (recal),
                .cal_acc(cal_acc),
                .cal_div(cal_div),
                .run    (run),
                .rate   (in_rate[gi*DATA_W +: DATA_W]),
                .angle  (angle_out[gi*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign out_valid   = out_valid_reg;
    assign calibrating = (state_reg != RUN);

endmodule

// File: tb/tb_gyro_integrator.sv
// tb_gyro_integrator: directed checks of gyro_integrator.
//   u_dut  : 3 channels, 48-bit accumulators, OUT_SHIFT=0 so angles are visible.
//   u_small: 1 channel, ACC_W=20, CAL_LOG2=2, OUT_SHIFT=4 for the overflow
//            and wrap/saturation cases (GYRO_ACC_SAT_EN selects expectation).
module tb_gyro_integrator;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, recal;
    logic [47:0] in_rate;
    logic [47:0] angle_out;
    logic        out_valid, calibrating;

    logic        s_valid, s_recal;
    logic [15:0] s_rate;
    logic [15:0] s_angle;
    logic        s_out_valid, s_cal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gyro_integrator #(
        .NUM_CH(3), .DATA_W(16), .ACC_W(48), .CAL_LOG2(8),
        .DEADBAND(200), .OUT_SHIFT(0)
    ) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_rate(in_rate),
        .recal(recal), .angle_out(angle_out), .out_valid(out_valid),
        .calibrating(calibrating)
    );

    gyro_integrator #(
        .NUM_CH(1), .DATA_W(16), .ACC_W(20), .CAL_LOG2(2),
        .DEADBAND(200), .OUT_SHIFT(4)
    ) u_small (
        .clk(clk), .reset(reset), .in_valid(s_valid), .in_rate(s_rate),
        .recal(s_recal), .angle_out(s_angle), .out_valid(s_out_valid),
        .calibrating(s_cal)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ang(input int ch);
        logic signed [15:0] a;
        a = angle_out[ch*16 +: 16];
        return longint'(a);
    endfunction

    function automatic longint s_ang();
        logic signed [15:0] a;
        a = s_angle;
        return longint'(a);
    endfunction

    task automatic set_rates(input int r0, input int r1, input int r2);
        in_rate = {16'(r2), 16'(r1), 16'(r0)};
    endtask

    task automatic check_angles(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_ch0"}, ang(0), longint'(e0));
        check({tag, "_ch1"}, ang(1), longint'(e1));
        check({tag, "_ch2"}, ang(2), longint'(e2));
    endtask

    initial begin
        longint m;
        reset = 1'b1; in_valid = 1'b0; recal = 1'b0; in_rate = '0;
        s_valid = 1'b0; s_recal = 1'b0; s_rate = '0;
        tick(); tick();
        reset = 1'b0;
        check_angles("reset_angle", 0, 0, 0);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_calibrating", longint'(calibrating), 1);

        // Gapped calibration: one valid in three cycles; ch1 mean of 50/150.
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1;
            set_rates(100, (k % 2 == 1) ? 150 : 50, -1000);
            tick();
            in_valid = 1'b0;
            if (k < 255) begin
                tick(); tick();
            end
            if (k == 254) check("cal_after_255", longint'(calibrating), 1);
        end
        check("cal_in_div", longint'(calibrating), 1);
        // Sample during CAL_DIV must be dropped.
        in_valid = 1'b1; set_rates(1000, 1000, 1000);
        tick();
        in_valid = 1'b0;
        check("run_calibrating", longint'(calibrating), 0);
        check("div_drop_no_valid", longint'(out_valid), 0);

        // Rate equal to the bias: corrected rate 0.
        in_valid = 1'b1; set_rates(100, 100, -1000);
        tick();
        in_valid = 1'b0;
        check("bias_out_valid", longint'(out_valid), 1);
        check_angles("bias_angle", 0, 0, 0);

        // |corr| == DEADBAND gives no accumulation.
        in_valid = 1'b1; set_rates(300, -100, -800);
        for (int k = 0; k < 10; k++) tick();
        in_valid = 1'b0;
        check_angles("deadband_edge", 0, 0, 0);
        tick();
        check("idle_out_valid", longint'(out_valid), 0);

        // |corr| == DEADBAND+1 integrates every sample.
        in_valid = 1'b1; set_rates(301, -101, -799);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("ramp%0d_valid", k), longint'(out_valid), 1);
            check_angles($sformatf("ramp%0d", k), 201 * k, -201 * k, 201 * k);
        end

        // recal together with in_valid: sample dropped, everything cleared.
        recal = 1'b1;
        tick();
        recal = 1'b0; in_valid = 1'b0;
        check_angles("recal_angle", 0, 0, 0);
        check("recal_calibrating", longint'(calibrating), 1);
        check("recal_out_valid", longint'(out_valid), 0);

        // Fresh calibration at zero rate needs all 256 samples.
        in_valid = 1'b1; set_rates(0, 0, 0);
        for (int k = 0; k < 255; k++) tick();
        check("recal_cal_255", longint'(calibrating), 1);
        tick();
        check("recal_cal_256", longint'(calibrating), 1);
        in_valid = 1'b0;
        tick();
        check("recal_run", longint'(calibrating), 0);
        in_valid = 1'b1; set_rates(500, -500, 1234);
        tick();
        in_valid = 1'b0;
        check("recal_sample_valid", longint'(out_valid), 1);
        check_angles("recal_sample", 500, -500, 1234);

        // Small config: bias -50, rate 32767 -> corr 32817 per sample.
        s_valid = 1'b1; s_rate = 16'(-50);
        for (int k = 0; k < 4; k++) tick();
        s_valid = 1'b0;
        check("s_cal_div", longint'(s_cal), 1);
        tick();
        check("s_run", longint'(s_cal), 0);
        m = 0;
        s_valid = 1'b1; s_rate = 16'sd32767;
        for (int k = 0; k < 17; k++) begin
            if (k == 16) s_rate = 16'h8000;
            tick();
            m += (k == 16) ? -32718 : 32817;
`ifdef GYRO_ACC_SAT_EN
            if (m > 524287) m = 524287;
            if (m < -524288) m = -524288;
`else
            if (m > 524287) m -= 1048576;
            if (m < -524288) m += 1048576;
`endif
            check($sformatf("s_valid%0d", k), longint'(s_out_valid), 1);
            check($sformatf("s_angle%0d", k), s_ang(), m >>> 4);
            if (k == 0) check("s_first_angle", s_ang(), 2051);
`ifdef GYRO_ACC_SAT_EN
            if (k == 15) check("s_sat_max", s_ang(), 32767);
            if (k == 16) check("s_sat_back", s_ang(), 30723);
`else
            if (k == 15) check("s_wrap_neg", s_ang(), -32719);
            if (k == 16) check("s_wrap_back", s_ang(), 30772);
`endif
        end
        s_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gyro_integrator.md
Name: gyro_integrator

Overview:
Parametrised multi-channel gyro rate integrator, the successor to the fixed three-axis angle block. Per channel it calibrates a resting bias over 2^CAL_LOG2 valid samples, then subtracts that bias, applies a symmetric deadband and integrates into a wide signed accumulator. Angles are scaled and sent to the game logic with a valid strobe. Sits between the gyro SPI reader and the racer steering logic.

Parameters:
NUM_CH, 3, number of independent rate channels
DATA_W, 16, signed width of each input rate and output angle
ACC_W, 48, signed accumulator width per channel (ACC_W > DATA_W + CAL_LOG2)
CAL_LOG2, 8, log2 of calibration sample count
DEADBAND, 200, magnitude below which corrected rate is treated as zero
OUT_SHIFT, 28, arithmetic right shift from accumulator to angle output

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_rate holds a new sample set this cycle
in_rate  in  NUM_CH*DATA_W  signed rates, channel i at [i*DATA_W +: DATA_W]
recal  in  1  single-cycle pulse: discard bias and angles, restart calibration
angle_out  out  NUM_CH*DATA_W  signed angles, same packing as in_rate
out_valid  out  1  angle_out updated this cycle
calibrating  out  1  high while in CAL_ACC or CAL_DIV

Behaviour:
- One clock (clk); reset is synchronous and active-high. Only clk edges with reset=1 clear state.
- Reset values: angle_out=0, out_valid=0, calibrating=1, FSM=CAL_ACC, sample counter=0, all sums, biases and accumulators=0.
- FSM CAL_ACC: on each in_valid, sign-extend every channel into its sum (DATA_W+CAL_LOG2 bits) and increment the counter. After the 2^CAL_LOG2-th accepted sample, go to CAL_DIV. Cycles without in_valid change nothing.
- CAL_DIV: one cycle. bias_i = sum_i >>> CAL_LOG2 (arithmetic, exact 2^N samples). Go to RUN. A sample arriving in this cycle is dropped.
- RUN: on in_valid, corr_i = in_rate_i - bias_i computed at DATA_W+1 bits, so it cannot overflow. If |corr_i| <= DEADBAND, contrib_i = 0. Otherwise contrib_i = corr_i sign-extended to ACC_W. acc_i += contrib_i.
- Output: angle_out_i = (acc_i >>> OUT_SHIFT)[DATA_W-1:0], registered. out_valid pulses one cycle after the accepted RUN sample, which gives a latency of 1 cycle from in_valid to out_valid. out_valid=0 outside RUN.
- recal asserted: the next state is CAL_ACC with counter, sums, biases, accumulators and angle_out cleared. recal overrides a simultaneous in_valid, and that sample is dropped. recal during CAL_ACC also restarts calibration.
- reset has priority over recal.
- The deadband boundary is inclusive: |corr| = DEADBAND gives 0, and DEADBAND+1 integrates.

Optional Feature:
GYRO_ACC_SAT_EN
- Defined: accumulator addition saturates at the signed ACC_W max/min and holds there until the opposite rate brings it back.
- Undefined: plain two's-complement wrap-around at ACC_W bits, so the angle wraps modulo.

Decomposition:
- Package gyro_pkg: FSM state enum (CAL_ACC, CAL_DIV, RUN), default width constants, and a signed saturating-add function used under the macro.
- Sub-module gyro_chan is instantiated NUM_CH times via generate. It holds sum, bias, deadband compare and accumulator, and takes cal_acc/cal_div/run/clear strobes from the top-level FSM and counter.

Test Plan:
- Reset then 256 valid samples of +100 on all channels -> calibrating falls after CAL_DIV, bias=100, a 257th sample of 100 gives out_valid with angle unchanged at 0.
- After bias=0, rate=+200 for 1000 samples -> no accumulation. Rate=+201 -> acc increments by 201 each sample, and out_valid follows every in_valid by exactly 1 cycle.
- Bias=-50, constant rate 2^15-1 with OUT_SHIFT=0, DATA_W=16 test config -> corr=32817 with no intermediate overflow, and acc matches the model after N samples.
- recal pulsed mid-RUN together with in_valid -> sample dropped, angle_out=0, calibrating=1, and a fresh 256-sample calibration is required.
- in_valid gapped (1 of 3 cycles) during calibration -> CAL_DIV only after 256 accepted samples, and the bias matches the mean.
- Large positive rate for ACC_W=20 config -> with GYRO_ACC_SAT_EN acc holds at 2^19-1, without it acc wraps negative.
